// File: rtl/mips_pc_unit_if.sv
// Redirect/trap request bundle into the PC stage and the fetch-address bundle out of it.
// The slave modport is the PC unit; the master modport is the decode/execute side.
interface mips_pc_unit_if;
    logic        Stall;
    logic        Branch;
    logic [15:0] BranchOffset;
    logic        Jump;
    logic [25:0] JumpTarget;
    logic        JumpReg;
    logic [31:0] RegTarget;
    logic        Exception;
    logic [31:0] PC;
    logic [31:0] PC_Plus4;
    logic        FetchValid;
    logic [31:0] EPC;
    logic        ExcMisalign;

    modport slave (
        input  Stall, Branch, BranchOffset, Jump, JumpTarget, JumpReg, RegTarget, Exception,
        output PC, PC_Plus4, FetchValid, EPC, ExcMisalign
    );

    modport master (
        output Stall, Branch, BranchOffset, Jump, JumpTarget, JumpReg, RegTarget, Exception,
        input  PC, PC_Plus4, FetchValid, EPC, ExcMisalign
    );
endinterface

// File: rtl/mips_pc_unit.sv
// MIPS program counter: sequential/branch/jump/JR/trap next-PC; MIPS_PC_DELAY_SLOT_EN adds a delay slot.
// Latency: 1 cycle from request to new PC; ExcMisalign is registered (cycle after the trap edge).
// Backpressure: Stall holds PC, EPC, state and any pending target; Exception overrides Stall.
module mips_pc_unit #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] EXC_VECTOR   = 32'h8000_0180
) (
    input  logic         Clk,
    input  logic         Reset,
    mips_pc_unit_if.slave bus
);
    typedef enum logic [1:0] {BOOT, RUN, TRAP} state_t;

    state_t      state, state_nxt;
    logic [31:0] pc, pc_nxt;
    logic [31:0] epc, epc_nxt;
    logic        exc_misalign, exc_misalign_nxt;
    logic [31:0] pc_plus4, br_target, j_target, redir_target;
    logic        redirect, accept_redirect, misalign, take_exc, active;

`ifdef MIPS_PC_DELAY_SLOT_EN
    logic        pend_vld, pend_vld_nxt;
    logic [31:0] pend_tgt, pend_tgt_nxt;
    assign accept_redirect = !pend_vld;
`else
    assign accept_redirect = 1'b1;
`endif

    assign active    = (state != BOOT);
    assign pc_plus4  = pc + 32'd4;
    assign br_target = pc_plus4 + {{14{bus.BranchOffset[15]}}, bus.BranchOffset, 2'b00};
    assign j_target  = {pc_plus4[31:28], bus.JumpTarget, 2'b00};
    assign redirect  = bus.JumpReg | bus.Jump | bus.Branch;

    always_comb begin
        redir_target = br_target;
        if (bus.JumpReg)   redir_target = bus.RegTarget;
        else if (bus.Jump) redir_target = j_target;
    end

    // A JR that is ignored (stalled, or shadowed by a pending delay-slot target) cannot trap.
    assign misalign = active && bus.JumpReg && (bus.RegTarget[1:0] != 2'b00)
                      && !bus.Stall && accept_redirect;
    assign take_exc = active && (bus.Exception || misalign);

    always_comb begin
        state_nxt        = state;
        pc_nxt           = pc;
        epc_nxt          = epc;
        exc_misalign_nxt = 1'b0;
`ifdef MIPS_PC_DELAY_SLOT_EN
        pend_vld_nxt     = pend_vld;
        pend_tgt_nxt     = pend_tgt;
`endif
        case (state)
            BOOT: begin
                if (!bus.Stall) state_nxt = RUN;
            end
            default: begin
                if (take_exc) begin
                    pc_nxt           = EXC_VECTOR;
                    epc_nxt          = pc;
                    state_nxt        = TRAP;
                    exc_misalign_nxt = misalign;
`ifdef MIPS_PC_DELAY_SLOT_EN
                    pend_vld_nxt     = 1'b0;
`endif
                end else if (!bus.Stall) begin
                    state_nxt = RUN;
`ifdef MIPS_PC_DELAY_SLOT_EN
                    if (pend_vld) begin
                        pc_nxt       = pend_tgt;
                        pend_vld_nxt = 1'b0;
                    end else if (redirect) begin
                        pc_nxt       = pc_plus4;
                        pend_vld_nxt = 1'b1;
                        pend_tgt_nxt = redir_target;
                    end else begin
                        pc_nxt = pc_plus4;
                    end
`else
                    pc_nxt = redirect ? redir_target : pc_plus4;
`endif
                end
            end
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state        <= BOOT;
            pc           <= RESET_VECTOR;
            epc          <= 32'd0;
            exc_misalign <= 1'b0;
`ifdef MIPS_PC_DELAY_SLOT_EN
            pend_vld     <= 1'b0;
            pend_tgt     <= 32'd0;
`endif
        end else begin
            state        <= state_nxt;
            pc           <= pc_nxt;
            epc          <= epc_nxt;
            exc_misalign <= exc_misalign_nxt;
`ifdef MIPS_PC_DELAY_SLOT_EN
            pend_vld     <= pend_vld_nxt;
            pend_tgt     <= pend_tgt_nxt;
`endif
        end
    end

    assign bus.PC          = pc;
    assign bus.PC_Plus4    = pc_plus4;
    assign bus.FetchValid  = active;
    assign bus.EPC         = epc;
    assign bus.ExcMisalign = exc_misalign;
endmodule

// File: tb/tb_mips_pc_unit.sv
// Self-checking bench for mips_pc_unit: vector table driven through a scoreboard, plus reset sequences.
module tb_mips_pc_unit;
    logic Clk = 1'b0;
    logic Reset = 1'b1;
    always #5 Clk = ~Clk;

    mips_pc_unit_if bus();
    mips_pc_unit dut (.Clk(Clk), .Reset(Reset), .bus(bus.slave));

    typedef struct {
        string       name;
        logic        st, br;
        logic [15:0] bo;
        logic        j;
        logic [25:0] jt;
        logic        jr;
        logic [31:0] rt;
        logic        ex;
        logic [31:0] pc, epc;
        logic        fv, mis;
    } vec_t;

    typedef struct {
        string       name;
        logic [31:0] pc, epc;
        logic        fv, mis;
    } exp_t;

    int   errors = 0;
    int   checks = 0;
    vec_t tbl[$];
    exp_t exp_q[$];

    function automatic vec_t mk(string n, logic st, logic br, logic [15:0] bo, logic j, logic [25:0] jt,
                                logic jr, logic [31:0] rt, logic ex, logic [31:0] pc, logic [31:0] epc,
                                logic mis);
        vec_t v;
        v.name = n; v.st = st; v.br = br; v.bo = bo; v.j = j; v.jt = jt;
        v.jr = jr; v.rt = rt; v.ex = ex; v.pc = pc; v.epc = epc; v.fv = 1'b1; v.mis = mis;
        return v;
    endfunction

    function automatic vec_t idle(string n, logic [31:0] pc, logic [31:0] epc);
        return mk(n, 0, 0, 16'h0, 0, 26'h0, 0, 32'h0, 0, pc, epc, 0);
    endfunction

    function automatic vec_t jreg(string n, logic [31:0] rt, logic [31:0] pc, logic [31:0] epc, logic mis);
        return mk(n, 0, 0, 16'h0, 0, 26'h0, 1, rt, 0, pc, epc, mis);
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(vec_t v);
        bus.Stall = v.st; bus.Branch = v.br; bus.BranchOffset = v.bo;
        bus.Jump = v.j; bus.JumpTarget = v.jt; bus.JumpReg = v.jr;
        bus.RegTarget = v.rt; bus.Exception = v.ex;
    endtask

    // Drive one request, expect its result one edge later.
    task automatic apply_vec(vec_t v);
        exp_t e;
        exp_t got;
        drive(v);
        e.name = v.name; e.pc = v.pc; e.epc = v.epc; e.fv = v.fv; e.mis = v.mis;
        exp_q.push_back(e);
        @(posedge Clk);
        #1;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty: got 0 entries expected 1");
        end else begin
            got = exp_q.pop_front();
            chk({got.name, ".pc"},     bus.PC,                 got.pc);
            chk({got.name, ".pc4"},    bus.PC_Plus4,           got.pc + 32'd4);
            chk({got.name, ".epc"},    bus.EPC,                got.epc);
            chk({got.name, ".fv"},     {31'd0, bus.FetchValid}, {31'd0, got.fv});
            chk({got.name, ".mis"},    {31'd0, bus.ExcMisalign}, {31'd0, got.mis});
        end
    endtask

    task automatic chk_reset_state(string nm);
        chk({nm, ".pc"},  bus.PC, 32'h0000_0000);
        chk({nm, ".epc"}, bus.EPC, 32'h0000_0000);
        chk({nm, ".fv"},  {31'd0, bus.FetchValid}, 32'd0);
        chk({nm, ".mis"}, {31'd0, bus.ExcMisalign}, 32'd0);
    endtask

    initial begin
        logic [31:0] last_pc, last_epc, jr700_pc;

`ifdef MIPS_PC_DELAY_SLOT_EN
        tbl.push_back(idle("boot_edge", 32'h0, 32'h0));
        tbl.push_back(idle("seq4", 32'h4, 32'h0));
        tbl.push_back(idle("seq8", 32'h8, 32'h0));
        tbl.push_back(jreg("jr100_slot", 32'h100, 32'hC, 32'h0, 0));
        tbl.push_back(idle("jr100_take", 32'h100, 32'h0));
        tbl.push_back(mk("br_slot", 0, 1, 16'hFFFE, 0, 26'h0, 0, 32'h0, 0, 32'h104, 32'h0, 0));
        tbl.push_back(idle("br_take", 32'hFC, 32'h0));
        tbl.push_back(jreg("jr2fc_slot", 32'h2FC, 32'h100, 32'h0, 0));
        tbl.push_back(idle("jr2fc_take", 32'h2FC, 32'h0));
        tbl.push_back(jreg("jr500_slot", 32'h500, 32'h300, 32'h0, 0));
        tbl.push_back(mk("exc_all", 1, 1, 16'h0010, 0, 26'h0, 0, 32'h0, 1, 32'h8000_0180, 32'h300, 0));
        tbl.push_back(idle("pend_dropped", 32'h8000_0184, 32'h300));
        tbl.push_back(jreg("jr_mis", 32'h1002, 32'h8000_0180, 32'h8000_0184, 1));
        tbl.push_back(idle("after_mis", 32'h8000_0184, 32'h8000_0184));
        tbl.push_back(jreg("jr400_slot", 32'h400, 32'h8000_0188, 32'h8000_0184, 0));
        tbl.push_back(mk("jump_ignored", 0, 0, 16'h0, 1, 26'h40, 0, 32'h0, 0, 32'h400, 32'h8000_0184, 0));
        tbl.push_back(idle("seq404", 32'h404, 32'h8000_0184));
        tbl.push_back(jreg("jr600_slot", 32'h600, 32'h408, 32'h8000_0184, 0));
        tbl.push_back(mk("stall_pend1", 1, 0, 16'h0, 0, 26'h0, 0, 32'h0, 0, 32'h408, 32'h8000_0184, 0));
        tbl.push_back(mk("stall_pend2", 1, 0, 16'h0, 0, 26'h0, 0, 32'h0, 0, 32'h408, 32'h8000_0184, 0));
        tbl.push_back(idle("jr600_take", 32'h600, 32'h8000_0184));
        tbl.push_back(jreg("jrfffc_slot", 32'hFFFF_FFFC, 32'h604, 32'h8000_0184, 0));
        tbl.push_back(idle("jrfffc_take", 32'hFFFF_FFFC, 32'h8000_0184));
        tbl.push_back(idle("seq_wrap", 32'h0, 32'h8000_0184));
`else
        tbl.push_back(idle("boot_edge", 32'h0, 32'h0));
        tbl.push_back(idle("seq4", 32'h4, 32'h0));
        tbl.push_back(idle("seq8", 32'h8, 32'h0));
        tbl.push_back(jreg("jr100", 32'h100, 32'h100, 32'h0, 0));
        tbl.push_back(mk("br_back", 0, 1, 16'hFFFE, 0, 26'h0, 0, 32'h0, 0, 32'hFC, 32'h0, 0));
        tbl.push_back(jreg("jr400010", 32'h0040_0010, 32'h0040_0010, 32'h0, 0));
        for (int i = 0; i < 3; i++)
            tbl.push_back(mk("stall_hold", 1, 0, 16'h0, 1, 26'h3, 0, 32'h0, 0, 32'h0040_0010, 32'h0, 0));
        tbl.push_back(mk("jump", 0, 0, 16'h0, 1, 26'h0000100, 0, 32'h0, 0, 32'h400, 32'h0, 0));
        tbl.push_back(jreg("jr200", 32'h200, 32'h200, 32'h0, 0));
        tbl.push_back(jreg("jr_mis", 32'h1002, 32'h8000_0180, 32'h200, 1));
        tbl.push_back(idle("after_mis", 32'h8000_0184, 32'h200));
        tbl.push_back(jreg("jr300", 32'h300, 32'h300, 32'h200, 0));
        tbl.push_back(mk("exc_all", 1, 1, 16'h0010, 0, 26'h0, 0, 32'h0, 1, 32'h8000_0180, 32'h300, 0));
        tbl.push_back(mk("trap_jump", 0, 0, 16'h0, 1, 26'h40, 0, 32'h0, 0, 32'h8000_0100, 32'h300, 0));
        tbl.push_back(jreg("jrfffc", 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h300, 0));
        tbl.push_back(mk("br_wrap", 0, 1, 16'h0001, 0, 26'h0, 0, 32'h0, 0, 32'h4, 32'h300, 0));
        tbl.push_back(jreg("jrfffc2", 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h300, 0));
        tbl.push_back(idle("seq_wrap", 32'h0, 32'h300));
`endif

        drive(idle("init", 32'h0, 32'h0));
        #1;
        chk_reset_state("reset_hold");
        repeat (2) @(posedge Clk);
        #1;
        Reset = 1'b0;
        #1;
        chk_reset_state("boot_pre_edge");

        foreach (tbl[i]) apply_vec(tbl[i]);

        last_pc  = tbl[tbl.size() - 1].pc;
        last_epc = tbl[tbl.size() - 1].epc;
`ifdef MIPS_PC_DELAY_SLOT_EN
        jr700_pc = last_pc + 32'd4;
`else
        jr700_pc = 32'h700;
`endif
        // Redirect in flight, then an asynchronous reset between edges must abort it.
        apply_vec(jreg("jr700", 32'h700, jr700_pc, last_epc, 0));
        drive(idle("quiet", 32'h0, 32'h0));
        #2;
        Reset = 1'b1;
        #1;
        chk_reset_state("async_reset");
        @(posedge Clk);
        #1;
        chk_reset_state("reset_across_edge");
        Reset = 1'b0;
        apply_vec(idle("reboot_edge", 32'h0, 32'h0));
        apply_vec(idle("reboot_seq4", 32'h4, 32'h0));

        chk("scoreboard_drained", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mips_pc_unit.md
# mips_pc_unit

Program-counter stage of the MIPS core. It holds the 32-bit fetch address and computes the next PC from sequential, branch, jump, jump-register and exception requests. It drives instruction memory directly and consumes the redirect signals produced by the decode/execute flip-flop registers. Its state elements are plain enable/reset registers.

## Interface
- RESET_VECTOR, 32'h0000_0000: PC value loaded on reset.
- EXC_VECTOR, 32'h8000_0180: PC value loaded on an exception.

- Clk  input  1  rising-edge clock.
- Reset  input  1  asynchronous, active-high reset.
- Stall  input  1  high: hold PC and all state this cycle.
- Branch  input  1  take branch (already resolved taken).
- BranchOffset  input  16  signed word offset.
- Jump  input  1  J/JAL redirect.
- JumpTarget  input  26  instr_index field.
- JumpReg  input  1  JR/JALR redirect.
- RegTarget  input  32  JR target address.
- Exception  input  1  external trap request.
- PC  output  32  current fetch address.
- PC_Plus4  output  32  PC + 4, modulo 2^32 (combinational from PC).
- FetchValid  output  1  PC is a valid fetch address this cycle.
- EPC  output  32  address of the trapped instruction.
- ExcMisalign  output  1  one-cycle pulse: JR target misaligned.

## Operation
- FSM states: BOOT, RUN, TRAP.
- BOOT: entered on Reset. Next edge goes to RUN. PC stays RESET_VECTOR and FetchValid=0.
- RUN: FetchValid=1. PC updates each edge per priority below.
- TRAP: entered for one cycle after any exception. PC=EXC_VECTOR and FetchValid=1. Next edge returns to RUN with normal update, and redirect inputs are honoured.
- Update priority, highest first:
  - Exception or misaligned JR.
  - Stall.
  - JumpReg.
  - Jump.
  - Branch.
  - Sequential.
- Targets, all arithmetic modulo 2^32:
  - Sequential: PC+4.
  - Branch: PC+4 + (sext(BranchOffset) << 2).
  - Jump: {PC_Plus4[31:28], JumpTarget, 2'b00}.
  - JumpReg: RegTarget.
- Misaligned JR (JumpReg=1 and RegTarget[1:0]≠0, not stalled):
  - Treated as an exception.
  - EPC <= PC, PC <= EXC_VECTOR.
  - ExcMisalign=1 for that cycle only.
- Exception: EPC <= PC, PC <= EXC_VECTOR, state to TRAP. Exception overrides Stall.
- Stall: PC, EPC, state and any pending delay-slot target are held.
- Redirect inputs in BOOT are ignored.

## Timing
- Reset (asynchronous) sets, immediately:
  - PC=RESET_VECTOR, EPC=0, FetchValid=0, ExcMisalign=0.
  - state=BOOT, pending target cleared.
- All other updates occur on the rising edge of Clk, with 1-cycle latency from request to new PC.
- Reset asserted mid-operation aborts everything, including a pending redirect.
- Wrap: PC=32'hFFFF_FFFC sequential gives 32'h0000_0000. Branch targets wrap the same way.
- ExcMisalign is a registered output, asserted in the cycle after the edge that took the trap.

## Configuration
- Macro: MIPS_PC_DELAY_SLOT_EN.
- Defined (MIPS delay-slot semantics):
  - A redirect edge loads PC+4 and latches the target into a pending register.
  - The next non-stalled edge loads the pending target.
  - A further redirect while pending is ignored.
  - An exception clears pending. EPC holds the trapping PC.
- Undefined: redirects take effect on the same edge (PC <= target directly), with no pending register.

## Test plan
- Reset and boot:
  - Assert Reset with Clk running, then release.
  - PC=0 and FetchValid=0 through the first edge.
  - Then PC sequence 0, 4, 8 with FetchValid=1.
- Branch:
  - At PC=0x100, Branch=1, BranchOffset=16'hFFFE.
  - Without macro, next PC=0xFC.
  - With macro, PC goes 0x104 then 0xFC.
- Stall plus jump:
  - At PC=0x0040_0010, Stall=1 for 3 cycles: PC holds.
  - Then Jump=1, JumpTarget=26'h0000_100: PC=0x0000_0400.
- Misaligned JR:
  - At PC=0x200, JumpReg=1, RegTarget=0x1002.
  - PC=0x8000_0180, EPC=0x200, ExcMisalign pulses once.
  - Next cycle PC=0x8000_0184.
- Simultaneous events:
  - Exception=1 with Stall=1 and Branch=1 at PC=0x300: EPC=0x300, PC=EXC_VECTOR.
  - With macro, a pending target set the cycle before is discarded.
- Wrap and async reset:
  - PC=0xFFFF_FFFC sequential: next PC=0.
  - Reset pulse mid-cycle: PC=RESET_VECTOR immediately, without waiting for an edge.
